// File: rtl/fc_pkg.sv
// Shared constants, state encoding and helpers for the FC layer controller.
// Imported by fc_feature_buf and fc_layer_ctrl.
package fc_pkg;

  localparam int FC_N_IN      = 8;
  localparam int FC_BIAS_ADDR = 8;
  localparam int FC_ADDR_W    = 4;
  localparam int FC_W_W       = 8;
  localparam int FC_B_W       = 16;
  localparam int FC_ACC_W     = 20;
  localparam int FC_IDX_W     = 3;
  localparam int FC_P_W       = 2 * FC_W_W;

  typedef logic [1:0] fc_state_t;

  localparam fc_state_t ST_LOAD  = 2'd0;
  localparam fc_state_t ST_MAC   = 2'd1;
  localparam fc_state_t ST_DRAIN = 2'd2;
  localparam fc_state_t ST_OUT   = 2'd3;

  // Sign-extend a 16-bit product or bias to accumulator width.
  function automatic logic signed [FC_ACC_W-1:0] sext16(
    input logic signed [FC_P_W-1:0] v
  );
    return {{(FC_ACC_W - FC_P_W){v[FC_P_W-1]}}, v};
  endfunction

endpackage

// File: rtl/fc_feature_buf.sv
// 8x8-bit feature register file: one synchronous write port,
// one combinational read port. Ports: clk, we, wr_idx, wr_data, rd_idx, rd_data.
module fc_feature_buf
  import fc_pkg::*;
(
  input  logic                       clk,
  input  logic                       we,
  input  logic [FC_IDX_W-1:0]        wr_idx,
  input  logic signed [FC_W_W-1:0]   wr_data,
  input  logic [FC_IDX_W-1:0]        rd_idx,
  output logic signed [FC_W_W-1:0]   rd_data
);

  logic signed [FC_W_W-1:0] mem [FC_N_IN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fc_layer_ctrl.sv
// FC layer controller: loads 8 features, MACs them against the weight ROM,
// adds the bias and presents a 20-bit result with valid/ready handshakes.
// Ports: clk, rst, in_valid/in_ready/in_data, rom_addr/rom_weight/rom_bias,
//        out_valid/out_ready/out_data.
module fc_layer_ctrl
  import fc_pkg::*;
#(
  parameter bit RELU_EN = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [FC_W_W-1:0]    in_data,
  output logic [FC_ADDR_W-1:0]        rom_addr,
  input  logic signed [FC_W_W-1:0]    rom_weight,
  input  logic signed [FC_B_W-1:0]    rom_bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [FC_ACC_W-1:0]  out_data
);

  fc_state_t                    state;
  logic [FC_IDX_W-1:0]          k;
  logic [FC_ADDR_W-1:0]         addr;
  logic [FC_IDX_W-1:0]          addr_prev;
  logic signed [FC_ACC_W-1:0]   acc;
  logic signed [FC_ACC_W-1:0]   res;

  logic                         buf_we;
  logic signed [FC_W_W-1:0]     feat;
  logic signed [FC_P_W-1:0]     prod;
  logic signed [FC_ACC_W-1:0]   sum_b;
  logic signed [FC_ACC_W-1:0]   final_v;
  logic                         last_addr;

  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_OUT);
  assign rom_addr  = addr;
  assign out_data  = res;

  assign buf_we = in_ready && in_valid;

  fc_feature_buf u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_idx  (k),
    .wr_data (in_data),
    .rd_idx  (addr_prev),
    .rd_data (feat)
  );

  // rom_weight arriving now belongs to the address presented last cycle,
  // so the feature is read at addr_prev.
  assign prod      = feat * rom_weight;
  assign last_addr = (addr == FC_ADDR_W'(FC_BIAS_ADDR));
  assign sum_b     = acc + sext16(rom_bias);

  always_comb begin
    final_v = sum_b;
    if (RELU_EN && sum_b[FC_ACC_W-1]) begin
      final_v = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      k         <= '0;
      addr      <= '0;
      addr_prev <= '0;
      acc       <= '0;
      res       <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            k <= k + 3'd1;
            if (k == 3'd7) begin
              state <= ST_MAC;
              acc   <= '0;
              addr  <= '0;
            end
          end
        end
        ST_MAC: begin
          addr_prev <= addr[FC_IDX_W-1:0];
          if (!last_addr) begin
            addr <= addr + 4'd1;
          end
          // The first MAC cycle has no weight returned yet.
          if (addr != '0) begin
            acc <= acc + sext16(prod);
          end
          if (last_addr) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          acc   <= sum_b;
          res   <= final_v;
          state <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            state <= ST_LOAD;
            k     <= '0;
            addr  <= '0;
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
